// File: rtl/mem_load_scan_pkg.sv
// Shared state encodings and default sizing for the memory loader/scanner.
package mem_load_scan_pkg;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_LOAD = 2'd1,
        MS_SCAN = 2'd2
    } ms_state_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_ADDR_W   = 2;
    localparam int DEF_AUTO_DIV = 50_000_000;

endpackage

// File: rtl/mem_load_scan_ram.sv
// ram_sp_sync: single-port RAM, synchronous write, registered read with read enable.
module ram_sp_sync #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Registered read port, held while reads are disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= {WIDTH{1'b0}};
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_load_scan.sv
// Loads DEPTH words over valid/ready, then scans them in address order on step pulses.
// Optional MEM_SCAN_AUTO_EN adds a free-running scan prescaler of AUTO_DIV cycles.
module mem_load_scan
    import mem_load_scan_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AUTO_DIV = DEF_AUTO_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr_valid,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_ready,
    input  logic              step,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              load_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    ms_state_e         state_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_valid_q;
    logic              load_done_q;
    logic              adv_s;
    logic              ram_we_s;
    logic              ram_re_s;
    logic [ADDR_W-1:0] ram_addr_s;

`ifdef MEM_SCAN_AUTO_EN
    localparam int CNT_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_DIV - 1);

    logic [CNT_W-1:0] pre_q;
    logic [CNT_W-1:0] pre_d;
    logic             auto_tick_s;

    // Prescaler runs only in SCAN; an external step restarts the interval.
    always_comb begin
        pre_d       = pre_q;
        auto_tick_s = 1'b0;
        if ((state_q != MS_SCAN) || step || start) begin
            pre_d = {CNT_W{1'b0}};
        end else if (pre_q == CNT_LAST) begin
            pre_d       = {CNT_W{1'b0}};
            auto_tick_s = 1'b1;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= {CNT_W{1'b0}};
        end else begin
            pre_q <= pre_d;
        end
    end

    assign adv_s = step | auto_tick_s;
`else
    assign adv_s = step;
`endif

    // Main FSM with write address, scan address and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MS_IDLE;
            waddr_q     <= {ADDR_W{1'b0}};
            rd_addr_q   <= {ADDR_W{1'b0}};
            rd_valid_q  <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                MS_IDLE: begin
                    if (start) begin
                        state_q <= MS_LOAD;
                        waddr_q <= {ADDR_W{1'b0}};
                    end
                end
                MS_LOAD: begin
                    if (wr_valid) begin
                        waddr_q <= waddr_q + 1'b1;
                        if (waddr_q == LAST_ADDR) begin
                            state_q     <= MS_SCAN;
                            rd_addr_q   <= {ADDR_W{1'b0}};
                            rd_valid_q  <= 1'b0;
                            load_done_q <= 1'b1;
                        end
                    end
                end
                MS_SCAN: begin
                    // start beats step: reload without advancing the scan address
                    if (start) begin
                        state_q    <= MS_LOAD;
                        waddr_q    <= {ADDR_W{1'b0}};
                        rd_valid_q <= 1'b0;
                    end else if (adv_s) begin
                        rd_addr_q  <= rd_addr_q + 1'b1;
                        rd_valid_q <= 1'b0;
                    end else begin
                        rd_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= MS_IDLE;
                    rd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ram_we_s   = (state_q == MS_LOAD) && wr_valid;
    assign ram_re_s   = (state_q == MS_SCAN);
    assign ram_addr_s = (state_q == MS_LOAD) ? waddr_q : rd_addr_q;

    ram_sp_sync #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .addr  (ram_addr_s),
        .wdata (wr_data),
        .rdata (rd_data)
    );

    assign wr_ready  = (state_q == MS_LOAD);
    assign busy      = (state_q == MS_LOAD);
    assign rd_addr   = rd_addr_q;
    assign rd_valid  = rd_valid_q;
    assign load_done = load_done_q;

endmodule

// File: tb/tb_mem_load_scan.sv
// Directed bench for mem_load_scan: vector table for load/scan/reload plus reset sequences.
module tb_mem_load_scan;

    logic       clk;
    logic       rst;
    logic       start;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       step;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       load_done;

    int n_vec;
    int n_err;

    typedef struct {
        logic       st;
        logic       wv;
        logic [7:0] wd;
        logic       sp;
        logic       rdy;
        logic       ld;
        logic [1:0] addr;
        logic       vld;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[31];

    mem_load_scan #(
        .WIDTH    (8),
        .ADDR_W   (2),
        .AUTO_DIV (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .step      (step),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .load_done (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic wv, input logic [7:0] wd, input logic sp);
        start    = st;
        wr_valid = wv;
        wr_data  = wd;
        step     = sp;
    endtask

    // One clock; inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic st, input logic wv, input logic [7:0] wd,
                           input logic sp, input logic rdy, input logic ld,
                           input logic [1:0] addr, input logic vld, input logic [7:0] data);
        vecs[i].st = st;  vecs[i].wv = wv;  vecs[i].wd = wd;  vecs[i].sp = sp;
        vecs[i].rdy = rdy; vecs[i].ld = ld; vecs[i].addr = addr;
        vecs[i].vld = vld; vecs[i].data = data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        drive(1'b0, 1'b0, 8'd0, 1'b0);
        do_reset();

        check("rst_wr_ready", int'(wr_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_load_done", int'(load_done), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_data", int'(rd_data), 0);

`ifdef MEM_SCAN_AUTO_EN
        // Auto-advance every 4 cycles, restarted by an external step.
        tick();
        drive(1'b1, 1'b0, 8'd0, 1'b0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'(i + 1), 1'b0); tick();
        end
        drive(1'b0, 1'b0, 8'd0, 1'b0);
        check("auto_load_done", int'(load_done), 1);
        for (int c = 1; c <= 9; c++) begin
            tick();
            check("auto_addr", int'(rd_addr), (c / 4) % 4);
        end
        drive(1'b0, 1'b0, 8'd0, 1'b1); tick();
        drive(1'b0, 1'b0, 8'd0, 1'b0);
        check("auto_step_addr", int'(rd_addr), 3);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("auto_restart_addr", int'(rd_addr), (c == 4) ? 0 : 3);
        end
`else
        // Columns: start, wr_valid, wr_data, step | wr_ready/busy, load_done, rd_addr, rd_valid, rd_data
        set_vec( 0, 1, 0,  0, 0,  1, 0, 0, 0,  0);
        set_vec( 1, 0, 1, 74, 0,  1, 0, 0, 0,  0);
        set_vec( 2, 0, 1, 29, 0,  1, 0, 0, 0,  0);
        set_vec( 3, 0, 1, 32, 0,  1, 0, 0, 0,  0);
        set_vec( 4, 0, 1, 20, 0,  0, 1, 0, 0,  0);
        set_vec( 5, 0, 0,  0, 0,  0, 0, 0, 1, 74);
        set_vec( 6, 0, 0,  0, 1,  0, 0, 1, 0, 74);
        set_vec( 7, 0, 0,  0, 0,  0, 0, 1, 1, 29);
        set_vec( 8, 0, 0,  0, 1,  0, 0, 2, 0, 29);
        set_vec( 9, 0, 0,  0, 0,  0, 0, 2, 1, 32);
        set_vec(10, 0, 0,  0, 1,  0, 0, 3, 0, 32);
        set_vec(11, 0, 0,  0, 0,  0, 0, 3, 1, 20);
        set_vec(12, 0, 0,  0, 1,  0, 0, 0, 0, 20);
        set_vec(13, 0, 0,  0, 0,  0, 0, 0, 1, 74);
        set_vec(14, 0, 0,  0, 1,  0, 0, 1, 0, 74);
        set_vec(15, 0, 0,  0, 1,  0, 0, 2, 0, 29);
        set_vec(16, 0, 0,  0, 0,  0, 0, 2, 1, 32);
        set_vec(17, 1, 0,  0, 1,  1, 0, 2, 0, 32);
        set_vec(18, 0, 1,  1, 0,  1, 0, 2, 0, 32);
        set_vec(19, 1, 0, 99, 1,  1, 0, 2, 0, 32);
        set_vec(20, 0, 1,  2, 0,  1, 0, 2, 0, 32);
        set_vec(21, 0, 0, 77, 0,  1, 0, 2, 0, 32);
        set_vec(22, 0, 1,  3, 0,  1, 0, 2, 0, 32);
        set_vec(23, 0, 1,  4, 0,  0, 1, 0, 0, 32);
        set_vec(24, 0, 0,  0, 0,  0, 0, 0, 1,  1);
        set_vec(25, 0, 0,  0, 1,  0, 0, 1, 0,  1);
        set_vec(26, 0, 0,  0, 0,  0, 0, 1, 1,  2);
        set_vec(27, 0, 0,  0, 1,  0, 0, 2, 0,  2);
        set_vec(28, 0, 0,  0, 0,  0, 0, 2, 1,  3);
        set_vec(29, 0, 0,  0, 1,  0, 0, 3, 0,  3);
        set_vec(30, 0, 0,  0, 0,  0, 0, 3, 1,  4);

        for (int i = 0; i < 31; i++) begin
            drive(vecs[i].st, vecs[i].wv, vecs[i].wd, vecs[i].sp);
            tick();
            check($sformatf("v%0d_wr_ready", i), int'(wr_ready), int'(vecs[i].rdy));
            check($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].rdy));
            check($sformatf("v%0d_load_done", i), int'(load_done), int'(vecs[i].ld));
            check($sformatf("v%0d_rd_addr", i), int'(rd_addr), int'(vecs[i].addr));
            check($sformatf("v%0d_rd_valid", i), int'(rd_valid), int'(vecs[i].vld));
            check($sformatf("v%0d_rd_data", i), int'(rd_data), int'(vecs[i].data));
        end
        drive(1'b0, 1'b0, 8'd0, 1'b0);

        // Asynchronous reset between clock edges while scanning.
        #2;
        rst = 1'b1;
        #1;
        check("arst_rd_addr", int'(rd_addr), 0);
        check("arst_rd_valid", int'(rd_valid), 0);
        check("arst_rd_data", int'(rd_data), 0);
        check("arst_wr_ready", int'(wr_ready), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_load_done", int'(load_done), 0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'd0, 1'b1); tick();
        check("idle_step_rd_addr", int'(rd_addr), 0);
        check("idle_step_rd_valid", int'(rd_valid), 0);
        check("idle_step_busy", int'(busy), 0);

        // Reset in the middle of a load, then a full reload.
        drive(1'b1, 1'b0, 8'd0, 1'b0); tick();
        drive(1'b0, 1'b1, 8'd9, 1'b0); tick();
        drive(1'b0, 1'b1, 8'd10, 1'b0); tick();
        drive(1'b0, 1'b0, 8'd0, 1'b0);
        check("midload_busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("midload_rst_busy", int'(busy), 0);
        check("midload_rst_wr_ready", int'(wr_ready), 0);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 8'd0, 1'b0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'(5 + i), 1'b0); tick();
        end
        drive(1'b0, 1'b0, 8'd0, 1'b0);
        check("reload_load_done", int'(load_done), 1);
        tick();
        check("reload_data0", int'(rd_data), 5);
        check("reload_valid0", int'(rd_valid), 1);
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 1'b0, 8'd0, 1'b1); tick();
            drive(1'b0, 1'b0, 8'd0, 1'b0); tick();
            check("reload_addr", int'(rd_addr), i);
            check("reload_data", int'(rd_data), 5 + i);
            check("reload_valid", int'(rd_valid), 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
